req_pending_tracker: RTL

REQ_PENDING_TRACKER -- requirements
Module: req_pending_tracker

---
 rtl/req_pending_pkg.sv | 20 ++
 rtl/req_pending_tracker_if.sv | 37 +++
 rtl/req_pending_counter.sv | 71 +++++++
 rtl/req_pending_tracker.sv | 76 +++++++
 4 files changed

// File: rtl/req_pending_pkg.sv
// req_pending_pkg
// Shared constants and width helpers for the pending-request tracker.
//   CLIENTS_DEFAULT : default number of requesting clients
//   DEPTH_DEFAULT   : default maximum outstanding requests per client
//   cnt_width()     : width of a per-client counter covering 0..depth
//   total_width()   : width of the sum of all per-client counters
package req_pending_pkg;

    localparam int CLIENTS_DEFAULT = 32;
    localparam int DEPTH_DEFAULT   = 4;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int total_width(input int clients, input int depth);
        return $clog2(clients * depth + 1);
    endfunction

endpackage

// File: rtl/req_pending_tracker_if.sv
// req_pending_tracker_if
// Bundles the request/grant side of the pending-request tracker.
//   push          : one new request per set bit (driven by the clients)
//   grant, stall  : arbiter grant vector and its not-accepted qualifier
//   request       : per-client "has pending work" toward the arbiter
//   full          : per-client counter at DEPTH
//   pending_total : registered sum of all per-client counters
//   overflow_err  : sticky, push into a full client
//   grant_err     : sticky, grant to an idle client or multi-hot grant
// Modports: master = client/arbiter side, slave = the tracker.
interface req_pending_tracker_if
    import req_pending_pkg::*;
#(
    parameter int CLIENTS = CLIENTS_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT
);
    localparam int TW = total_width(CLIENTS, DEPTH);

    logic [CLIENTS-1:0] push;
    logic [CLIENTS-1:0] grant;
    logic               stall;
    logic [CLIENTS-1:0] request;
    logic [CLIENTS-1:0] full;
    logic [TW-1:0]      pending_total;
    logic               overflow_err;
    logic               grant_err;

    modport master (
        output push, grant, stall,
        input  request, full, pending_total, overflow_err, grant_err
    );

    modport slave (
        input  push, grant, stall,
        output request, full, pending_total, overflow_err, grant_err
    );
endinterface

// File: rtl/req_pending_counter.sv
// req_pending_counter
// Saturating up/down counter of outstanding requests for one client.
//   clock, reset : clock and synchronous active-high reset
//   push         : one new request this cycle
//   consume      : one grant accepted this cycle
//   cnt_next     : next counter value (lets the parent register a total
//                  that matches the counter in the same cycle)
//   request      : counter non-zero (registered-state decode)
//   full         : counter at DEPTH (registered-state decode)
//   overflow     : pulse, push dropped because the counter was full
//   underflow    : pulse, consume while the counter was empty
module req_pending_counter
    import req_pending_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          consume,
    output logic [CW-1:0] cnt_next,
    output logic          request,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);
    logic [CW-1:0] cnt_reg;
    logic          at_max;
    logic          at_zero;

    assign at_max  = (cnt_reg == CW'(DEPTH));
    assign at_zero = (cnt_reg == '0);

    always_comb begin
        cnt_next  = cnt_reg;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (reset) begin
            cnt_next = '0;
        end else begin
            unique case ({push, consume})
                2'b10: begin
                    if (at_max) overflow = 1'b1;
                    else        cnt_next = cnt_reg + 1'b1;
                end
                2'b01: begin
                    if (at_zero) underflow = 1'b1;
                    else         cnt_next  = cnt_reg - 1'b1;
                end
                2'b11: begin
                    // The consume found nothing to retire, so the push
                    // still lands; otherwise they cancel, even when full.
                    if (at_zero) begin
                        underflow = 1'b1;
                        cnt_next  = CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_reg <= '0;
        else       cnt_reg <= cnt_next;
    end

    assign request = !at_zero;
    assign full    = at_max;
endmodule

// File: rtl/req_pending_tracker.sv
// req_pending_tracker
// Tracks outstanding requests per client and presents a request-stable
// request vector to a round-robin arbiter.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : push/grant/stall in; request/full/pending_total and
//                  sticky overflow_err/grant_err out
module req_pending_tracker
    import req_pending_pkg::*;
#(
    parameter int CLIENTS = CLIENTS_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    req_pending_tracker_if.slave  bus
);
    localparam int CW = cnt_width(DEPTH);
    localparam int TW = total_width(CLIENTS, DEPTH);

    logic [CLIENTS-1:0] consume;
    logic [CLIENTS-1:0] overflow_vec;
    logic [CLIENTS-1:0] underflow_vec;
    logic [CW-1:0]      cnt_next [CLIENTS];
    logic               multi_grant;
    logic [TW-1:0]      total_next;
    logic [TW-1:0]      pending_total_reg;
    logic               overflow_err_reg;
    logic               grant_err_reg;

    assign consume = bus.grant & ~{CLIENTS{bus.stall}};

    generate
        for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_client
            req_pending_counter #(.DEPTH(DEPTH)) u_counter (
                .clock     (clock),
                .reset     (reset),
                .push      (bus.push[gi]),
                .consume   (consume[gi]),
                .cnt_next  (cnt_next[gi]),
                .request   (bus.request[gi]),
                .full      (bus.full[gi]),
                .overflow  (overflow_vec[gi]),
                .underflow (underflow_vec[gi])
            );
        end
    endgenerate

    // Clearing the lowest set bit leaves something only if two or more
    // bits were set.
    assign multi_grant = |(consume & (consume - 1'b1));

    // Summing next-state values keeps the registered total aligned with
    // the registered counters.
    always_comb begin
        total_next = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            total_next = total_next + TW'(cnt_next[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_total_reg <= '0;
            overflow_err_reg  <= 1'b0;
            grant_err_reg     <= 1'b0;
        end else begin
            pending_total_reg <= total_next;
            overflow_err_reg  <= overflow_err_reg | (|overflow_vec);
            grant_err_reg     <= grant_err_reg | (|underflow_vec) | multi_grant;
        end
    end

    assign bus.pending_total = pending_total_reg;
    assign bus.overflow_err  = overflow_err_reg;
    assign bus.grant_err     = grant_err_reg;
endmodule
